mem_arbiter: RTL and testbench

Two-requester arbiter sharing the processor's single memory port between the multicycle control unit/datapath (CPU port) and the crypto engine (CRY port). Each requester uses a level req / one-cycle done handshake, matching the control unit's wait-for-done memory states. The arbiter selects one requester with round-robin priority, latches its command, drives the memory port until `mem_done`, and returns the response with a done pulse.

---
 rtl/mem_arbiter_if.sv | 20 ++
 rtl/mem_arbiter.sv | 53 +++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, crypto and memory port signals of the shared-memory arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              cpu_req, cpu_we, cpu_done;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cry_req, cry_we, cry_done;
  logic [ADDR_W-1:0] cry_addr;
  logic [DATA_W-1:0] cry_wdata, cry_rdata;
  logic              mem_req, mem_we, mem_done, owner;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cry_req, cry_we, cry_addr, cry_wdata, mem_rdata, mem_done,
    output cpu_done, cpu_rdata, cry_done, cry_rdata, mem_req, mem_we, mem_addr, mem_wdata, owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cry_req, cry_we, cry_addr, cry_wdata, mem_rdata, mem_done,
    input  cpu_done, cpu_rdata, cry_done, cry_rdata, mem_req, mem_we, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between the CPU and the crypto engine.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic [DATA_W-1:0] rdata;
  logic grant_cry;
  // on a tie the requester that did not own the port last time wins
  assign grant_cry = bus.cry_req & (~bus.cpu_req | ~bus.owner);
  assign bus.cpu_rdata = rdata;
  assign bus.cry_rdata = rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rdata         <= '0;
      bus.cpu_done  <= 1'b0;
      bus.cry_done  <= 1'b0;
      bus.owner     <= 1'b1;
    end else begin
      bus.cpu_done <= 1'b0;
      bus.cry_done <= 1'b0;
      case (state)
        IDLE: if (bus.cpu_req | bus.cry_req) begin
          bus.owner     <= grant_cry;
          bus.mem_we    <= grant_cry ? bus.cry_we : bus.cpu_we;
          bus.mem_addr  <= grant_cry ? bus.cry_addr : bus.cpu_addr;
          bus.mem_wdata <= grant_cry ? bus.cry_wdata : bus.cpu_wdata;
          bus.mem_req   <= 1'b1;
          state         <= BUSY;
        end
        BUSY: if (bus.mem_done) begin
          rdata        <= bus.mem_rdata;
          bus.mem_req  <= 1'b0;
          bus.cpu_done <= ~bus.owner;
          bus.cry_done <= bus.owner;
          state        <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a done-driven scoreboard and a simple latency-programmable memory model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  typedef struct {logic who; logic [31:0] rdata;} exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int mem_lat = 1;
  logic [31:0] mem_val = '0;
  logic spur = 1'b0;
  int mem_txns = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_mem_req"}, {31'b0, b.mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, b.mem_we}, 32'd0);
    check({tag, "_mem_addr"}, b.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, b.mem_wdata, 32'd0);
    check({tag, "_cpu_done"}, {31'b0, b.cpu_done}, 32'd0);
    check({tag, "_cry_done"}, {31'b0, b.cry_done}, 32'd0);
    check({tag, "_rdata"}, b.cpu_rdata, 32'd0);
    check({tag, "_owner"}, {31'b0, b.owner}, 32'd1);
  endtask
  // memory answers mem_lat cycles after mem_req rises with mem_val ^ mem_addr
  initial begin
    int cnt;
    cnt = 0;
    b.mem_done = 1'b0;
    b.mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        b.mem_done = 1'b0;
        cnt = 0;
      end else if (b.mem_req && !b.mem_done) begin
        cnt++;
        if (cnt >= mem_lat) begin
          b.mem_done = 1'b1;
          b.mem_rdata = mem_val ^ b.mem_addr;
        end
      end else begin
        b.mem_done = spur;
        cnt = 0;
      end
    end
  end
  initial forever begin
    @(posedge b.mem_req);
    mem_txns++;
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (b.cpu_done && b.cry_done) begin
        tests++;
        fails++;
        $display("FAIL both_done: cpu_done=1 cry_done=1 required at most one");
      end else if (b.cpu_done || b.cry_done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: cpu_done=%b cry_done=%b with no pending request", b.cpu_done, b.cry_done);
        end else begin
          e = sb.pop_front();
          check("done_who", {31'b0, b.cry_done}, {31'b0, e.who});
          check("owner_at_done", {31'b0, b.owner}, {31'b0, e.who});
          check("cpu_rdata", b.cpu_rdata, e.rdata);
          check("cry_rdata", b.cry_rdata, e.rdata);
        end
      end
    end
  end
  task automatic run(input logic who, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    int n;
    n = 0;
    if (who) begin
      b.cry_we = we; b.cry_addr = addr; b.cry_wdata = wdata; b.cry_req = 1'b1;
    end else begin
      b.cpu_we = we; b.cpu_addr = addr; b.cpu_wdata = wdata; b.cpu_req = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(who ? b.cry_done : b.cpu_done) && n < 200);
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL timeout: requester %0d saw no done within %0d cycles", who, n);
    end
    if (hold) @(negedge clk);
    if (who) b.cry_req = 1'b0;
    else b.cpu_req = 1'b0;
  endtask
  initial begin
    int t0, n;
    bit seen;
    b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = '0; b.cpu_wdata = '0;
    b.cry_req = 0; b.cry_we = 0; b.cry_addr = '0; b.cry_wdata = '0;
    #1 rst_n = 1'b0;
    #1 check_reset("por");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk) spur = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_mem_req", {31'b0, b.mem_req}, 32'd0);
    check("spur_txns", mem_txns, 32'd0);
    mem_lat = 1;
    mem_val = 32'hDEADBEAF;
    sb.push_back('{1'b0, 32'hDEADBEEF});
    b.cpu_we = 1'b0; b.cpu_addr = 32'h40; b.cpu_req = 1'b1;
    @(negedge clk);
    check("c1_mem_req", {31'b0, b.mem_req}, 32'd1);
    check("c1_mem_addr", b.mem_addr, 32'h40);
    check("c1_mem_we", {31'b0, b.mem_we}, 32'd0);
    @(negedge clk);
    check("c2_cpu_done", {31'b0, b.cpu_done}, 32'd1);
    check("c2_cry_done", {31'b0, b.cry_done}, 32'd0);
    b.cpu_req = 1'b0;
    @(negedge clk);
    mem_lat = 5;
    mem_val = '0;
    sb.push_back('{1'b1, 32'h100});
    fork
      run(1'b1, 1'b1, 32'h100, 32'h12345678, 1'b0);
      begin
        int c, w;
        c = 0; w = 0;
        while (!b.mem_req && w < 20) begin
          @(negedge clk);
          w++;
        end
        while (b.mem_req && c < 50) begin
          c++;
          check("busy_mem_addr", b.mem_addr, 32'h100);
          check("busy_mem_wdata", b.mem_wdata, 32'h12345678);
          check("busy_mem_we", {31'b0, b.mem_we}, 32'd1);
          if (c == 2) b.cry_addr = 32'h200;
          @(negedge clk);
        end
        check("busy_cycles", c, 32'd5);
      end
    join
    mem_lat = 1;
    mem_val = 32'h5;
    t0 = mem_txns;
    sb.push_back('{1'b0, 32'h85});
    run(1'b0, 1'b0, 32'h80, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    check("no_regrant_txns", mem_txns - t0, 32'd1);
    check("no_regrant_mem_req", {31'b0, b.mem_req}, 32'd0);
    mem_lat = 4;
    mem_val = '0;
    sb.push_back('{1'b0, 32'hC0});
    b.cpu_we = 1'b0; b.cpu_addr = 32'hC0; b.cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    b.cpu_req = 1'b0;
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = b.cpu_done;
      n++;
    end
    check("abandon_done", {31'b0, seen}, 32'd1);
    @(negedge clk);
    mem_lat = 1000;
    b.cpu_we = 1'b1; b.cpu_addr = 32'h44; b.cpu_wdata = 32'hFF; b.cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_mem_req", {31'b0, b.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_busy");
    b.cpu_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    mem_lat = 1;
    mem_val = '0;
    @(negedge clk);
    sb.push_back('{1'b0, 32'h10});
    sb.push_back('{1'b1, 32'h20});
    sb.push_back('{1'b0, 32'h10});
    sb.push_back('{1'b1, 32'h20});
    fork
      begin
        repeat (2) begin
          run(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
          @(negedge clk);
        end
      end
      begin
        repeat (2) begin
          run(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
          @(negedge clk);
        end
      end
    join
    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
